// File: rtl/psum_lane_serializer_pkg.sv
// rtl/psum_lane_serializer_pkg.sv - occupancy encoding and lane-index width helper for the serializer
package psum_lane_serializer_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_state_t;

  function automatic int lane_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/psum_lane_serializer_if.sv
// rtl/psum_lane_serializer_if.sv - wide vector in, one lane per beat out
interface psum_lane_serializer_if #(
  parameter int N_STACK = 4,
  parameter int DW_DATA = 32
);
  import psum_lane_serializer_pkg::*;

  localparam int LW = lane_width(N_STACK);

  logic                       in_valid;
  logic                       in_ready;
  logic [N_STACK*DW_DATA-1:0] in_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [DW_DATA-1:0]         out_data;
  logic [LW-1:0]              out_lane;
  logic                       out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_lane, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_lane, out_last
  );

endinterface

// File: rtl/psum_vec_fifo2.sv
// rtl/psum_vec_fifo2.sv - two-entry vector buffer; head is always cur, nxt backs it up
module psum_vec_fifo2 #(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [W-1:0] push_data,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] head
);
  import psum_lane_serializer_pkg::*;

  occ_state_t   state, state_next;
  logic [W-1:0] cur, cur_next;
  logic [W-1:0] nxt, nxt_next;
  logic         push, pop;

  assign push_ready = (state != OCC_TWO);
  assign pop_valid  = (state != OCC_EMPTY);
  assign head       = cur;
  assign push       = push_valid && push_ready;
  assign pop        = pop_valid && pop_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= OCC_EMPTY;
      cur   <= '0;
      nxt   <= '0;
    end else begin
      state <= state_next;
      cur   <= cur_next;
      nxt   <= nxt_next;
    end
  end

  always_comb begin
    state_next = state;
    cur_next   = cur;
    nxt_next   = nxt;
    unique case (state)
      OCC_EMPTY: begin
        if (push) begin
          state_next = OCC_ONE;
          cur_next   = push_data;
        end
      end
      OCC_ONE: begin
        // Same-cycle push and pop replaces cur directly so the next vector starts without a bubble.
        if (push && pop) begin
          cur_next = push_data;
        end else if (push) begin
          state_next = OCC_TWO;
          nxt_next   = push_data;
        end else if (pop) begin
          state_next = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        if (pop) begin
          state_next = OCC_ONE;
          cur_next   = nxt;
        end
      end
      default: state_next = OCC_EMPTY;
    endcase
  end

endmodule

// File: rtl/psum_lane_serializer.sv
// rtl/psum_lane_serializer.sv - drains buffered partial-sum vectors one lane per beat, lane 0 first
module psum_lane_serializer #(
  parameter int N_STACK = 4,
  parameter int DW_DATA = 32
) (
  input logic                  clk,
  input logic                  rst,
  psum_lane_serializer_if.slave bus
);
  import psum_lane_serializer_pkg::*;

  localparam int            LW        = lane_width(N_STACK);
  localparam logic [LW-1:0] LAST_LANE = LW'(N_STACK - 1);

  logic [N_STACK*DW_DATA-1:0] head;
  logic                       head_valid;
  logic [LW-1:0]              lane;
  logic                       last;
  logic                       beat;
  logic                       pop;
  logic [DW_DATA-1:0]         lanes [N_STACK];

  assign last = (lane == LAST_LANE);
  assign beat = head_valid && bus.out_ready;
  assign pop  = beat && last;

  psum_vec_fifo2 #(
    .W(N_STACK * DW_DATA)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (bus.in_valid),
    .push_ready (bus.in_ready),
    .push_data  (bus.in_data),
    .pop_valid  (head_valid),
    .pop_ready  (pop),
    .head       (head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      lane <= '0;
    end else if (beat) begin
      lane <= last ? '0 : lane + LW'(1);
    end
  end

  for (genvar i = 0; i < N_STACK; i++) begin : g_unpack
    assign lanes[i] = head[i*DW_DATA +: DW_DATA];
  end

  assign bus.out_valid = head_valid;
  assign bus.out_data  = lanes[lane];
  assign bus.out_lane  = lane;
  assign bus.out_last  = last;

endmodule

// File: tb/tb_psum_lane_serializer.sv
// tb/tb_psum_lane_serializer.sv - randomized bench for the lane serializer, N_STACK=4 and N_STACK=1 instances
module tb_psum_lane_serializer;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  // Reference model: flat queue of lanes still owed downstream, in emission order.
  logic [31:0] qa [$];
  logic [31:0] qb [$];

  psum_lane_serializer_if #(.N_STACK(4), .DW_DATA(32)) ia ();
  psum_lane_serializer_if #(.N_STACK(1), .DW_DATA(32)) ib ();

  psum_lane_serializer #(.N_STACK(4), .DW_DATA(32)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ia)
  );

  psum_lane_serializer #(.N_STACK(1), .DW_DATA(32)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [36:0] exp_a();
    int          s;
    logic [1:0]  ln;
    logic [31:0] d;
    s  = qa.size();
    ln = 2'((4 - (s % 4)) % 4);
    d  = (s > 0) ? qa[0] : 32'h0;
    return {s > 0, s <= 4, (s % 4) == 1, ln, d};
  endfunction

  function automatic logic [36:0] obs_a();
    return {ia.out_valid, ia.in_ready, ia.out_last, ia.out_lane,
            ia.out_valid ? ia.out_data : 32'h0};
  endfunction

  function automatic logic [35:0] exp_b();
    int s;
    s = qb.size();
    return {s > 0, s < 2, 1'b1, 1'b0, (s > 0) ? qb[0] : 32'h0};
  endfunction

  function automatic logic [35:0] obs_b();
    return {ib.out_valid, ib.in_ready, ib.out_last, ib.out_lane,
            ib.out_valid ? ib.out_data : 32'h0};
  endfunction

  function automatic logic [127:0] rand_vec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    bit           push_a, beat_a, push_b, beat_b, r;
    logic [127:0] da;
    logic [31:0]  db;
    r      = rst;
    push_a = ia.in_valid && (qa.size() <= 4);
    beat_a = (qa.size() > 0) && ia.out_ready;
    da     = ia.in_data;
    push_b = ib.in_valid && (qb.size() < 2);
    beat_b = (qb.size() > 0) && ib.out_ready;
    db     = ib.in_data;
    @(posedge clk);
    if (r) begin
      qa.delete();
      qb.delete();
    end else begin
      if (beat_a) void'(qa.pop_front());
      if (push_a) for (int i = 0; i < 4; i++) qa.push_back(da[i*32 +: 32]);
      if (beat_b) void'(qb.pop_front());
      if (push_b) qb.push_back(db);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ia.in_valid = 1'b0; ia.out_ready = 1'b0; ia.in_data = '0;
    ib.in_valid = 1'b0; ib.out_ready = 1'b0; ib.in_data = '0;
    tick();
    tick();
    rst = 1'b0;
    n_checks++;
    if (ia.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", ia.out_valid); else n_pass++;
    n_checks++;
    if (ia.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", ia.in_ready); else n_pass++;
    n_checks++;
    if (ia.out_lane !== 2'd0) $display("FAIL reset_out_lane: got %0d want 0", ia.out_lane); else n_pass++;
    n_checks++;
    if (ia.out_data !== 32'h0) $display("FAIL reset_out_data: got %h want 0", ia.out_data); else n_pass++;
    n_checks++;
    if (ia.out_last !== 1'b0) $display("FAIL reset_out_last4: got %b want 0", ia.out_last); else n_pass++;
    n_checks++;
    if (ib.out_last !== 1'b1) $display("FAIL reset_out_last1: got %b want 1", ib.out_last); else n_pass++;
  endtask

  task automatic test_single();
    logic [31:0] vals [4];
    vals = '{32'h11, 32'h22, 32'h33, 32'h44};
    ia.in_data  = {32'h44, 32'h33, 32'h22, 32'h11};
    ia.in_valid = 1'b1;
    ia.out_ready = 1'b1;
    tick();
    ia.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({ia.out_valid, ia.out_data, ia.out_lane, ia.out_last} !== {1'b1, vals[k], 2'(k), k == 3})
        $display("FAIL single_beat%0d: got v=%b d=%h l=%0d last=%b want v=1 d=%h l=%0d last=%b",
                 k, ia.out_valid, ia.out_data, ia.out_lane, ia.out_last, vals[k], k, k == 3);
      else n_pass++;
      n_checks++;
      if (obs_a() !== exp_a()) $display("FAIL single_model%0d: got %h want %h", k, obs_a(), exp_a()); else n_pass++;
      tick();
    end
    n_checks++;
    if (ia.out_valid !== 1'b0) $display("FAIL single_after: got out_valid=%b want 0", ia.out_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [127:0] va, vb;
    logic [31:0]  want;
    va = rand_vec();
    vb = rand_vec();
    ia.out_ready = 1'b1;
    ia.in_valid  = 1'b1;
    ia.in_data   = va;
    tick();
    ia.in_data = vb;
    tick();
    ia.in_valid = 1'b0;
    // Beat k=0 happened during the B push; remaining beats are k=1..7.
    for (int k = 1; k < 8; k++) begin
      want = (k < 4) ? va[k*32 +: 32] : vb[(k-4)*32 +: 32];
      n_checks++;
      if ({ia.out_valid, ia.out_data, ia.in_ready} !== {1'b1, want, !(k >= 1 && k <= 3)})
        $display("FAIL b2b_beat%0d: got v=%b d=%h rdy=%b want v=1 d=%h rdy=%b",
                 k, ia.out_valid, ia.out_data, ia.in_ready, want, !(k >= 1 && k <= 3));
      else n_pass++;
      n_checks++;
      if (obs_a() !== exp_a()) $display("FAIL b2b_model%0d: got %h want %h", k, obs_a(), exp_a()); else n_pass++;
      tick();
    end
    n_checks++;
    if (ia.out_valid !== 1'b0) $display("FAIL b2b_after: got out_valid=%b want 0", ia.out_valid); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [34:0] snap;
    int          beats;
    ia.out_ready = 1'b1;
    ia.in_valid  = 1'b1;
    ia.in_data   = rand_vec();
    tick();
    ia.in_data = rand_vec();
    tick();
    ia.in_valid = 1'b0;
    tick();
    ia.out_ready = 1'b0;
    ia.in_valid  = 1'b1;
    ia.in_data   = rand_vec();
    snap = {ia.out_data, ia.out_lane, ia.out_last};
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if ({ia.out_data, ia.out_lane, ia.out_last, ia.in_ready} !== {snap[34:3], 2'd2, 1'b0, 1'b0})
        $display("FAIL stall_hold%0d: got d=%h l=%0d last=%b rdy=%b want d=%h l=2 last=0 rdy=0",
                 c, ia.out_data, ia.out_lane, ia.out_last, ia.in_ready, snap[34:3]);
      else n_pass++;
      n_checks++;
      if (obs_a() !== exp_a()) $display("FAIL stall_model%0d: got %h want %h", c, obs_a(), exp_a()); else n_pass++;
      tick();
    end
    ia.in_valid  = 1'b0;
    ia.out_ready = 1'b1;
    beats = 0;
    for (int c = 0; c < 12; c++) begin
      n_checks++;
      if (obs_a() !== exp_a()) $display("FAIL stall_drain%0d: got %h want %h", c, obs_a(), exp_a()); else n_pass++;
      if (ia.out_valid && ia.out_ready) beats++;
      tick();
    end
    n_checks++;
    if (beats !== 6) $display("FAIL stall_beat_count: got %0d want 6", beats); else n_pass++;
  endtask

  task automatic test_push_pop_last();
    logic [127:0] vb;
    ia.out_ready = 1'b1;
    ia.in_valid  = 1'b1;
    ia.in_data   = rand_vec();
    tick();
    ia.in_valid = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    n_checks++;
    if ({ia.out_last, ia.out_lane} !== {1'b1, 2'd3}) $display("FAIL pp_at_last: got last=%b l=%0d want last=1 l=3", ia.out_last, ia.out_lane); else n_pass++;
    vb = rand_vec();
    ia.in_valid = 1'b1;
    ia.in_data  = vb;
    tick();
    ia.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({ia.out_valid, ia.out_lane, ia.out_data, ia.in_ready} !== {1'b1, 2'(k), vb[k*32 +: 32], 1'b1})
        $display("FAIL pp_beat%0d: got v=%b l=%0d d=%h rdy=%b want v=1 l=%0d d=%h rdy=1",
                 k, ia.out_valid, ia.out_lane, ia.out_data, ia.in_ready, k, vb[k*32 +: 32]);
      else n_pass++;
      tick();
    end
    n_checks++;
    if (ia.out_valid !== 1'b0) $display("FAIL pp_after: got out_valid=%b want 0", ia.out_valid); else n_pass++;
  endtask

  task automatic test_reset_mid_drain();
    logic [127:0] vc;
    ia.out_ready = 1'b1;
    ia.in_valid  = 1'b1;
    ia.in_data   = rand_vec();
    tick();
    ia.in_data = rand_vec();
    tick();
    ia.in_valid = 1'b0;
    n_checks++;
    if ({ia.out_lane, ia.in_ready} !== {2'd1, 1'b0}) $display("FAIL rmd_setup: got l=%0d rdy=%b want l=1 rdy=0", ia.out_lane, ia.in_ready); else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({ia.out_valid, ia.in_ready, ia.out_lane, ia.out_data} !== {1'b0, 1'b1, 2'd0, 32'h0})
      $display("FAIL rmd_reset: got v=%b rdy=%b l=%0d d=%h want v=0 rdy=1 l=0 d=0",
               ia.out_valid, ia.in_ready, ia.out_lane, ia.out_data);
    else n_pass++;
    vc = rand_vec();
    ia.in_valid = 1'b1;
    ia.in_data  = vc;
    tick();
    ia.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({ia.out_valid, ia.out_lane, ia.out_data} !== {1'b1, 2'(k), vc[k*32 +: 32]})
        $display("FAIL rmd_fresh%0d: got v=%b l=%0d d=%h want v=1 l=%0d d=%h",
                 k, ia.out_valid, ia.out_lane, ia.out_data, k, vc[k*32 +: 32]);
      else n_pass++;
      tick();
    end
    n_checks++;
    if (ia.out_valid !== 1'b0) $display("FAIL rmd_after: got out_valid=%b want 0", ia.out_valid); else n_pass++;
  endtask

  task automatic test_random4();
    for (int c = 0; c < 150; c++) begin
      ia.in_valid  = ($urandom_range(0, 2) != 0);
      ia.in_data   = rand_vec();
      ia.out_ready = ($urandom_range(0, 3) != 0);
      n_checks++;
      if (obs_a() !== exp_a()) $display("FAIL rand4_cyc%0d: got %h want %h", c, obs_a(), exp_a()); else n_pass++;
      tick();
    end
    ia.in_valid  = 1'b0;
    ia.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    n_checks++;
    if (ia.out_valid !== 1'b0) $display("FAIL rand4_drain: got out_valid=%b want 0", ia.out_valid); else n_pass++;
  endtask

  task automatic test_single_lane();
    int accepted, emitted;
    accepted = 0;
    emitted  = 0;
    for (int c = 0; c < 200; c++) begin
      ib.in_valid  = $urandom_range(0, 1) == 1;
      ib.in_data   = $urandom;
      ib.out_ready = $urandom_range(0, 1) == 1;
      n_checks++;
      if (obs_b() !== exp_b()) $display("FAIL lane1_cyc%0d: got %h want %h", c, obs_b(), exp_b()); else n_pass++;
      if (ib.in_valid && qb.size() < 2) accepted++;
      if (ib.out_valid && ib.out_ready) emitted++;
      tick();
    end
    ib.in_valid  = 1'b0;
    ib.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (ib.out_valid && ib.out_ready) emitted++;
      tick();
    end
    n_checks++;
    if (emitted !== accepted) $display("FAIL lane1_count: got %0d beats want %0d", emitted, accepted); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    ia.in_valid = 1'b0; ia.out_ready = 1'b0; ia.in_data = '0;
    ib.in_valid = 1'b0; ib.out_ready = 1'b0; ib.in_data = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_push_pop_last();
    test_reset_mid_drain();
    test_random4();
    test_single_lane();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/psum_lane_serializer.md
# psum_lane_serializer

Drain side of the stacked partial-sum adder. Accepts one `N_STACK`-lane result vector per handshake and emits it one `DW_DATA` lane per beat, lane 0 first, toward the narrow write-back/output path. A two-entry vector buffer lets the next vector be accepted while the current one drains, so back-to-back vectors stream with no bubble.

## Interface
Parameters:
- `N_STACK`, 4: lanes per input vector; must be ≥1.
- `DW_DATA`, 32: bits per lane.
- `LW` (localparam): `N_STACK>1 ? $clog2(N_STACK) : 1`, the width of the lane index.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: input vector valid.
- `in_ready` out 1: the block can accept a vector this cycle.
- `in_data` in `N_STACK*DW_DATA`: packed vector; lane i is `[i*DW_DATA +: DW_DATA]`.
- `out_valid` out 1: output lane valid.
- `out_ready` in 1: downstream accepts the lane.
- `out_data` out `DW_DATA`: current lane value.
- `out_lane` out `LW`: index of the current lane.
- `out_last` out 1: high when `out_lane == N_STACK-1`.

## Operation
- Storage: two vector registers, `cur` and `nxt`, plus an occupancy state and a lane counter `lane`.
- Occupancy states:
  - `EMPTY`: 0 vectors held.
  - `ONE`: `cur` is valid.
  - `TWO`: `cur` and `nxt` are valid.
- Handshake events:
  - Push = `in_valid && in_ready`.
  - Pop = `out_valid && out_ready && out_last`.
  - Beat = `out_valid && out_ready`.
- Output and ready decode:
  - `in_ready = (state != TWO)`, decoded from registers only; it never depends on `in_valid` or `out_ready`.
  - `out_valid = (state != EMPTY)`.
  - `out_data` = lane `lane` of `cur`.
  - `out_lane = lane`.
- Lane counter:
  - A beat with `!out_last` increments `lane`.
  - A pop sets `lane` to 0.
- State transitions:
  - `EMPTY` + push → `ONE`; `cur` ← `in_data`.
  - `ONE` + push, no pop → `TWO`; `nxt` ← `in_data`.
  - `ONE` + pop, no push → `EMPTY`.
  - `ONE` + push + pop → `ONE`; `cur` ← `in_data` (the new vector starts at lane 0 the next cycle).
  - `TWO` + pop → `ONE`; `cur` ← `nxt`. Push is impossible here because `in_ready` = 0.
  - Any state with no event holds all registers.
- Stall rule: while `out_valid && !out_ready`, `out_data`, `out_lane` and `out_last` hold stable.
- `N_STACK==1`: `out_last` is constant 1, `lane` stays 0, and every beat is a pop.
- No arithmetic is performed; data passes through bit-exact.

## Timing
- Reset values:
  - `out_valid` = 0, `in_ready` = 1, `out_lane` = 0, `out_last` = (`N_STACK==1`).
  - `out_data` = 0: both vector registers clear to 0.
  - State = `EMPTY`.
- Reset mid-drain discards both held vectors and the lane position. No partial vector is re-emitted after reset.
- Latency: a push in cycle t gives lane 0 on `out_valid` in cycle t+1 when the block was `EMPTY`.
- Throughput: one lane per cycle with `out_ready` held high, i.e. one vector per `N_STACK` cycles sustained. With a source that is always valid there are no idle output cycles between vectors.
- Capacity: 2 vectors. `in_ready` deasserts in the cycle after the second push and reasserts in the cycle after the pop of `cur`.
- All outputs are functions of registers only; there is no combinational path from inputs to outputs.

## Structure
- No shared package types are required. `LW` is computed locally.
- A natural sub-module is `psum_vec_fifo2`: the 2-entry vector buffer with valid/ready on both sides.
  - The serializer instantiates it and adds the lane counter and the mux.
  - The buffer's pop is driven by the serializer's pop.

## Test plan
1. Single vector, `N_STACK`=4, `DW_DATA`=32, `in_data`={0x44,0x33,0x22,0x11} (lane 3…0), `out_ready`=1.
   - Beats in cycles t+1..t+4: 0x11, 0x22, 0x33, 0x44.
   - `out_lane` 0..3; `out_last` only on 0x44; `out_valid` low at t+5.
2. Back-to-back: push vector A, then hold `in_valid`=1 with vector B, `out_ready`=1.
   - 8 consecutive beats, A lanes then B lanes, with no gap.
   - `in_ready` pattern matches the occupancy rules.
3. Backpressure: `out_ready`=0 for 5 cycles at lane 2.
   - `out_data`, `out_lane`=2 and `out_last`=0 stay stable.
   - A third push is refused (`in_ready`=0) while 2 vectors are held.
4. Simultaneous push and pop in state `ONE` on the `out_last` beat.
   - The next cycle shows the new vector's lane 0; state remains `ONE`; no vector is lost or duplicated.
5. Reset asserted at lane 1 of vector A with B buffered.
   - Next cycle: `out_valid`=0, `in_ready`=1, `out_lane`=0, `out_data`=0.
   - A fresh vector then drains from lane 0.
6. `N_STACK`=1: every accepted value emits one beat with `out_last`=1 and `out_lane`=0.
   - Random valid/ready toggling gives output equal to the input order (scoreboard).
